// File: rtl/m3_pkg.sv
// Shared definitions for the M3 six-step commutation path: FSM states, step
// gate pattern table and the period limits shared with the speed calculator.
package m3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } m3_state_e;

   localparam int unsigned M3_PERIOD_MIN = 40;
   localparam int unsigned M3_PERIOD_MAX = 4000000;
   localparam int unsigned M3_DEAD_CYC   = 4;

   typedef struct packed {
      logic [2:0] hi;
      logic [2:0] lo;
   } m3_gate_t;

   // bit0=U, bit1=V, bit2=W; hi and lo never share a phase in any entry
   localparam m3_gate_t M3_STEP_PAT [6] = '{
      '{hi: 3'b001, lo: 3'b010},
      '{hi: 3'b001, lo: 3'b100},
      '{hi: 3'b010, lo: 3'b100},
      '{hi: 3'b010, lo: 3'b001},
      '{hi: 3'b100, lo: 3'b001},
      '{hi: 3'b100, lo: 3'b010}
   };

   function automatic m3_gate_t m3_step_pat(input logic [2:0] idx);
      m3_gate_t g;
      g = '{hi: 3'b000, lo: 3'b000};
      if (idx < 3'd6) g = M3_STEP_PAT[idx];
      return g;
   endfunction

   function automatic logic [2:0] m3_idx_next(input logic [2:0] idx, input logic rev);
      logic [2:0] n;
      if (rev) n = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
      else     n = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
      return n;
   endfunction

endpackage

// File: rtl/m3_step_timer.sv
// Step period timer: clamps and latches the requested period, counts each
// step down from len-1 and flags the terminal count (step boundary).
module m3_step_timer
   import m3_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PERIOD_MIN = M3_PERIOD_MIN,
   parameter int PERIOD_MAX = M3_PERIOD_MAX
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic             hold_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] round_len_i,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] len_clamped;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // zero falls under the lower bound, so it also maps to LEN_MIN
   always_comb begin
      len_clamped = round_len_i;
      if (round_len_i < LEN_MIN)      len_clamped = LEN_MIN;
      else if (round_len_i > LEN_MAX) len_clamped = LEN_MAX;
   end

   always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         len_d = len_clamped;
         cnt_d = len_clamped - CNT_ONE;
      end else if (hold_i) begin
         cnt_d = len_q - CNT_ONE;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         len_q <= LEN_MIN;
         cnt_q <= '0;
      end else begin
         len_q <= len_d;
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/m3_phase_step_gen.sv
// Six-step three-phase gate sequencer paced by the speed calculator's period.
// Optional gate dead time at every step start: define M3_DEADTIME_EN.
//
// state   | meaning
// IDLE    | not working; gates off, index 0
// RUN     | stepping; pattern of current index driven
// HOLD    | force-stop; gates off, index and period kept
module m3_phase_step_gen
   import m3_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PERIOD_MIN = M3_PERIOD_MIN,
   parameter int PERIOD_MAX = M3_PERIOD_MAX
`ifdef M3_DEADTIME_EN
 , parameter int DEAD_CYC   = M3_DEAD_CYC
`endif
) (
   input  logic             clkI,
   input  logic             nRstI,
   input  logic             workingI,
   input  logic             m3forceStopI,
   input  logic             m3invRotateI,
   input  logic [CNT_W-1:0] roundLenI,
   output logic [2:0]       phaseHiO,
   output logic [2:0]       phaseLoO,
   output logic [2:0]       stepIdxO,
   output logic             nextRound_1O
);

   m3_state_e  state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] hi_q, hi_d;
   logic [2:0] lo_q, lo_d;
   logic       pulse_q, pulse_d;
   logic       tm_load, tm_hold, tm_clear, tm_tc;
   logic       step_start;
   logic       gate_en;
   m3_gate_t   pat;

   m3_step_timer #(
      .CNT_W      (CNT_W),
      .PERIOD_MIN (PERIOD_MIN),
      .PERIOD_MAX (PERIOD_MAX)
   ) u_timer (
      .clk_i       (clkI),
      .rst_n_i     (nRstI),
      .load_i      (tm_load),
      .hold_i      (tm_hold),
      .clear_i     (tm_clear),
      .round_len_i (roundLenI),
      .tc_o        (tm_tc)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pulse_d    = 1'b0;
      tm_load    = 1'b0;
      tm_hold    = 1'b0;
      tm_clear   = 1'b0;
      step_start = 1'b0;
      if (!workingI) begin
         state_d  = ST_IDLE;
         idx_d    = 3'd0;
         tm_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!m3forceStopI) begin
                  state_d    = ST_RUN;
                  idx_d      = 3'd0;
                  tm_load    = 1'b1;
                  step_start = 1'b1;
               end else begin
                  tm_clear   = 1'b1;
               end
            end
            ST_RUN: begin
               if (m3forceStopI) begin
                  state_d = ST_HOLD;
                  tm_hold = 1'b1;
               end else if (tm_tc) begin
                  idx_d      = m3_idx_next(idx_q, m3invRotateI);
                  tm_load    = 1'b1;
                  step_start = 1'b1;
                  pulse_d    = m3invRotateI ? (idx_q == 3'd0) : (idx_q == 3'd5);
               end
            end
            ST_HOLD: begin
               // keeping the counter at len-1 makes the resumed step full length
               tm_hold = 1'b1;
               if (!m3forceStopI) begin
                  state_d    = ST_RUN;
                  step_start = 1'b1;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               idx_d    = 3'd0;
               tm_clear = 1'b1;
            end
         endcase
      end
   end

`ifdef M3_DEADTIME_EN
   localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam logic [DW-1:0] DEAD_LOAD = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

   logic [DW-1:0] dead_q, dead_d;

   // dead_q counts the off cycles still owed after the current one
   always_comb begin
      dead_d  = dead_q;
      gate_en = 1'b1;
      if (state_d != ST_RUN) begin
         dead_d = '0;
      end else if (step_start) begin
         dead_d  = DEAD_LOAD;
         gate_en = (DEAD_CYC == 0);
      end else if (dead_q != '0) begin
         dead_d  = dead_q - DW'(1);
         gate_en = 1'b0;
      end
   end

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) dead_q <= '0;
      else        dead_q <= dead_d;
   end
`else
   assign gate_en = 1'b1;
`endif

   always_comb begin
      pat  = m3_step_pat(idx_d);
      hi_d = 3'b000;
      lo_d = 3'b000;
      if ((state_d == ST_RUN) && gate_en) begin
         hi_d = pat.hi;
         lo_d = pat.lo;
      end
   end

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         hi_q    <= 3'b000;
         lo_q    <= 3'b000;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pulse_q <= pulse_d;
      end
   end

   assign phaseHiO     = hi_q;
   assign phaseLoO     = lo_q;
   assign stepIdxO     = idx_q;
   assign nextRound_1O = pulse_q;

endmodule
